// File: rtl/life_row_renderer.sv
// Render stage of the Game-of-Life VGA core: prefetches one board row during
// hblank into a double buffer, then draws each live cell as an 8x8 icon.
module life_row_renderer #(
  parameter int LOG_W   = 5,
  parameter int LOG_H   = 4,
  parameter int CELL_SH = 3,
  parameter int X0      = 64,
  parameter int Y0      = 48,
  parameter int H_FETCH = 640,
  parameter int H_LAST  = 799
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [9:0]             hpos,
  input  logic [9:0]             vpos,
  input  logic                   display_on,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic                   rd_req,
  input  logic                   rd_gnt,
  output logic                   rd_en,
  output logic [LOG_W+LOG_H-1:0] rd_addr,
  input  logic                   rd_data,
  output logic [1:0]             r,
  output logic [1:0]             g,
  output logic [1:0]             b,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   fetch_err
);

  localparam int W = 1 << LOG_W;
  localparam logic [9:0] X0_V      = 10'(X0);
  localparam logic [9:0] Y0_V      = 10'(Y0);
  localparam logic [9:0] H_FETCH_V = 10'(H_FETCH);
  localparam logic [9:0] H_LAST_V  = 10'(H_LAST);
  localparam logic [9:0] BOARD_W_V = 10'(W << CELL_SH);
  localparam logic [9:0] BOARD_H_V = 10'((1 << LOG_H) << CELL_SH);
  localparam logic [LOG_W-1:0] COL_LAST = {LOG_W{1'b1}};

  typedef enum logic [1:0] {IDLE, REQ, READ, DONE} state_t;

  state_t           state_q, state_d;
  logic [LOG_W-1:0] col_q, col_d;
  logic [LOG_H-1:0] row_q, row_d;
  logic             issued_q, issued_d;
  logic             cap_pend_q, cap_pend_d;
  logic [LOG_W-1:0] cap_col_q, cap_col_d;
  logic [W-1:0]     fetch_buf_q, fetch_buf_d;
  logic [W-1:0]     disp_buf_q, disp_buf_d;
  logic             rd_req_q, rd_req_d;
  logic             fetch_err_q, fetch_err_d;

  logic             inf_q, inf_d;
  logic             cell_q, cell_d;
  logic             ic_q, ic_d;
  logic             de1_q, de1_d;
  logic             hs1_q, hs1_d;
  logic             vs1_q, vs1_d;
  logic [1:0]       r_q, r_d;
  logic [1:0]       g_q, g_d;
  logic [1:0]       b_q, b_d;
  logic             hs2_q, hs2_d;
  logic             vs2_q, vs2_d;

  logic [9:0] ny, dyf, dx, dy;
  logic       at_last, trigger, hit, rd_en_c;
  logic [7:0] icon_bits;

  function automatic logic [7:0] icon_row(input logic [2:0] y);
    case (y)
      3'd0, 3'd7: icon_row = 8'h00;
      3'd1, 3'd6: icon_row = 8'h3C;
      default:    icon_row = 8'h7E;
    endcase
  endfunction

  // Wrapped (negative) offsets land far above the board size, so the unsigned
  // range compares below double as lower-bound checks.
  assign ny        = vpos + 10'd1;
  assign dyf       = ny - Y0_V;
  assign dx        = hpos - X0_V;
  assign dy        = vpos - Y0_V;
  assign at_last   = (hpos == H_LAST_V);
  assign trigger   = (hpos == H_FETCH_V) && (dyf < BOARD_H_V);
  assign hit       = (dx < BOARD_W_V) && (dy < BOARD_H_V);
  assign icon_bits = icon_row(dy[2:0]);
  assign rd_en_c   = (state_q == READ) && !issued_q && rd_gnt && !at_last;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    issued_d    = issued_q;
    cap_pend_d  = rd_en_c;
    cap_col_d   = col_q;
    fetch_buf_d = fetch_buf_q;
    disp_buf_d  = disp_buf_q;
    rd_req_d    = rd_req_q;
    fetch_err_d = fetch_err_q;

    if (cap_pend_q) fetch_buf_d[cap_col_q] = rd_data;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = REQ;
          rd_req_d = 1'b1;
          row_d    = dyf[CELL_SH +: LOG_H];
          col_d    = '0;
          issued_d = 1'b0;
        end
      end
      REQ: begin
        if (rd_gnt) state_d = READ;
      end
      READ: begin
        if (rd_en_c) begin
          col_d = col_q + 1'b1;
          if (col_q == COL_LAST) issued_d = 1'b1;
        end
        if (cap_pend_q && (cap_col_q == COL_LAST)) begin
          state_d  = DONE;
          rd_req_d = 1'b0;
        end
      end
      DONE: begin
        if (at_last) begin
          disp_buf_d = fetch_buf_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Missing the line deadline abandons the row; the old row stays on screen.
    if (((state_q == REQ) || (state_q == READ)) && at_last) begin
      state_d     = IDLE;
      rd_req_d    = 1'b0;
      fetch_err_d = 1'b1;
    end
  end

  always_comb begin
    inf_d  = display_on & hit;
    cell_d = disp_buf_q[dx[CELL_SH +: LOG_W]];
    ic_d   = icon_bits[dx[2:0]];
    de1_d  = display_on;
    hs1_d  = hsync_in;
    vs1_d  = vsync_in;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    r_d    = 2'b00;
    g_d    = 2'b00;
    b_d    = 2'b00;
    if (de1_q) begin
      b_d = 2'b01;
      if (inf_q) begin
        r_d = {cell_q & ic_q, 1'b1};
        g_d = {cell_q & ic_q, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      issued_q    <= 1'b0;
      cap_pend_q  <= 1'b0;
      cap_col_q   <= '0;
      fetch_buf_q <= '0;
      disp_buf_q  <= '0;
      rd_req_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      inf_q       <= 1'b0;
      cell_q      <= 1'b0;
      ic_q        <= 1'b0;
      de1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      r_q         <= 2'b00;
      g_q         <= 2'b00;
      b_q         <= 2'b00;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      issued_q    <= issued_d;
      cap_pend_q  <= cap_pend_d;
      cap_col_q   <= cap_col_d;
      fetch_buf_q <= fetch_buf_d;
      disp_buf_q  <= disp_buf_d;
      rd_req_q    <= rd_req_d;
      fetch_err_q <= fetch_err_d;
      inf_q       <= inf_d;
      cell_q      <= cell_d;
      ic_q        <= ic_d;
      de1_q       <= de1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_en     = rd_en_c;
  assign rd_addr   = {row_q, col_q};
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_life_row_renderer.sv
// Scoreboard bench for life_row_renderer: drives synthetic scan lines, models
// the board memory and arbiter, and checks read addresses and pixels.
module tb_life_row_renderer;

  localparam int MODE_NORMAL   = 0;
  localparam int MODE_RANDOM   = 1;
  localparam int MODE_STALL    = 2;
  localparam int MODE_DEADLINE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in;
  logic       rd_req, rd_gnt, rd_en;
  logic [8:0] rd_addr;
  logic       rd_data;
  logic [1:0] r, g, b;
  logic       hsync_out, vsync_out, fetch_err;

  logic [31:0] board [16];
  logic [31:0] model_disp;
  logic        model_err;
  logic [7:0]  pix_q [$];
  logic [8:0]  addr_q [$];
  int          checks = 0;
  int          passes = 0;
  int          grant_count = 0;
  int          grant_base = 0;
  int          stall_left = 0;
  int          line_mode = MODE_NORMAL;
  bit          monitor_on = 1'b0;

  always #5 clk = ~clk;

  life_row_renderer dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .r(r), .g(g), .b(b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .fetch_err(fetch_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Board memory: one-cycle read latency on granted reads.
  always @(posedge clk) begin
    if (rd_en && rd_gnt) rd_data <= board[rd_addr[8:5]][rd_addr[4:0]];
  end

  always @(negedge clk) begin : addr_monitor
    if (monitor_on && rd_en && rd_gnt) begin
      grant_count++;
      if (addr_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL rd_addr_extra: got read of %0d, expected none", rd_addr);
      end else begin
        checkOutput("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin : pix_monitor
    logic [7:0] e;
    if (monitor_on) begin
      while (pix_q.size() > 2) begin
        e = pix_q.pop_front();
        checkOutput("pixel", 32'({r, g, b, hsync_out, vsync_out}), 32'(e));
      end
    end
  end

  function automatic logic [7:0] expectedPixel(input int h, input int v,
                                               input bit de, input bit hs, input bit vs);
    logic [7:0] icon [8];
    logic [7:0] row_bits;
    logic [1:0] rg, bb;
    logic       lit;
    icon = '{8'h00, 8'h3C, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h3C, 8'h00};
    rg = 2'b00;
    bb = 2'b00;
    if (de) begin
      bb = 2'b01;
      if (h >= 64 && h < 320 && v >= 48 && v < 176) begin
        row_bits = icon[(v - 48) % 8];
        lit = model_disp[(h - 64) / 8] & row_bits[(h - 64) % 8];
        rg = {lit, 1'b1};
      end
    end
    return {rg, rg, bb, hs, vs};
  endfunction

  task automatic applyStimulus(input int h, input int v);
    bit de, hs, vs;
    @(posedge clk);
    #1;
    de = (h < 640) && (v < 480);
    hs = (h >= 656) && (h < 752);
    vs = (v == 490) || (v == 491);
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = de;
    hsync_in = hs;
    vsync_in = vs;
    case (line_mode)
      MODE_NORMAL: rd_gnt = 1'b1;
      MODE_RANDOM: rd_gnt = ($urandom_range(3, 0) != 0);
      MODE_STALL: begin
        if ((grant_count - grant_base) == 12 && stall_left > 0) begin
          rd_gnt = 1'b0;
          stall_left--;
        end else rd_gnt = 1'b1;
      end
      default: rd_gnt = 1'b0;
    endcase
    pix_q.push_back(expectedPixel(h, v, de, hs, vs));
  endtask

  // One scan line: board-area pixels, then hblank including the fetch window.
  task automatic runLine(input int v, input int mode, input int stop_at);
    int ny, row;
    bit trig;
    ny = (v + 1) % 1024;
    trig = (ny >= 48) && (ny < 176);
    row = (ny - 48) / 8;
    line_mode = mode;
    stall_left = 10;
    grant_base = grant_count;
    if (trig && mode != MODE_DEADLINE)
      for (int c = 0; c < 32; c++) addr_q.push_back(9'(row * 32 + c));
    for (int h = 61; h <= 323; h++) applyStimulus(h, v);
    for (int h = 636; h <= 799; h++) begin
      applyStimulus(h, v);
      if (h == stop_at) return;
    end
    if (trig) begin
      if (mode == MODE_DEADLINE) model_err = 1'b1;
      else model_disp = board[row];
    end
    applyStimulus(0, (v + 1) % 525);
    applyStimulus(1, (v + 1) % 525);
    checkOutput("fetch_err", 32'(fetch_err), 32'(model_err));
    checkOutput("rd_req_idle", 32'(rd_req), 32'd0);
    checkOutput("addr_drain", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    hpos = '0; vpos = '0;
    display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    rd_gnt = 1'b0;
    for (int i = 0; i < 16; i++) board[i] = $urandom;
    board[5] = 32'hA5A5A5A5;
    model_disp = '0;
    model_err = 1'b0;

    #12;
    checkOutput("reset_outputs",
                32'({r, g, b, hsync_out, vsync_out, rd_req, rd_en, fetch_err}), 32'd0);
    #10 rst_n = 1'b1;
    monitor_on = 1'b1;

    runLine(87, MODE_NORMAL, -1);
    runLine(51, MODE_NORMAL, -1);
    runLine(100, MODE_STALL, -1);
    runLine(101, MODE_NORMAL, -1);
    runLine(120, MODE_DEADLINE, -1);
    runLine(130, MODE_NORMAL, -1);
    runLine(524, MODE_NORMAL, -1);
    runLine(175, MODE_NORMAL, -1);
    runLine(176, MODE_NORMAL, -1);
    runLine(490, MODE_NORMAL, -1);
    runLine(47, MODE_NORMAL, -1);
    for (int i = 0; i < 12; i++)
      runLine(int'($urandom_range(175, 40)), int'($urandom_range(2, 0)), -1);

    runLine(87, MODE_NORMAL, 650);
    checkOutput("rd_en_mid_read", 32'(rd_en), 32'd1);
    monitor_on = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async", 32'({rd_req, rd_en, r, g, b}), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    model_disp = '0;
    model_err = 1'b0;
    pix_q.delete();
    addr_q.delete();
    checkOutput("fetch_err_after_reset", 32'(fetch_err), 32'd0);
    monitor_on = 1'b1;

    runLine(90, MODE_NORMAL, -1);
    runLine(92, MODE_STALL, -1);
    for (int i = 0; i < 5; i++)
      runLine(int'($urandom_range(175, 40)), int'($urandom_range(2, 0)), -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
